// File: rtl/zilla_imem_pkg.sv
// Shared widths, FSM encoding and address helpers for the Zilla imem bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package zilla_imem_pkg;

  localparam int          IMEM_DATA_WIDTH  = 64;
  localparam int          IMEM_ADDR_WIDTH  = 20;
  localparam logic [19:0] IMEM_BASE_ADDR   = 20'h08000;
  localparam int          IMEM_DEPTH_WORDS = 32768;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } imem_state_e;

  // True when base <= addr < base + 8*depth_words. Computed at 36 bits so
  // the upper limit cannot wrap for any 32-bit base/depth combination.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] depth_words);
    logic [35:0] lim;
    lim = {4'b0, base} + {1'b0, depth_words, 3'b0};
    return ({4'b0, addr} >= {4'b0, base}) && ({4'b0, addr} < lim);
  endfunction

  // Word index of a byte address; only meaningful when addr_in_range holds.
  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input logic [31:0] base);
    return (addr - base) >> 3;
  endfunction

endpackage

// File: rtl/zilla_imem_ram.sv
// Simple dual-port array: one registered read-first read port, one byte-enabled write port.
// Latency: read data valid 1 cycle after rd_en; writes commit at the sampling edge.
// Backpressure: none; accepts one read and one write every cycle.
// Ports: clk; wr_en/wr_addr/wr_data/wr_strb write port; rd_en/rd_addr read port; rd_data_o.
module zilla_imem_ram #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 32768,
  parameter int AW         = 15
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic                    rd_en,
  input  logic [AW-1:0]           rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data_o
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Read and write share one clocked block with non-blocking updates, so a
  // same-address collision returns the old word (read-first).
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
    if (wr_en) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (wr_strb[b]) begin
          mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/zilla_imem_bank.sv
// Zilla instruction memory bank: post-reset zero sweep, strobed writes, rotated 32-bit-aligned reads.
// Latency: read data/valid/error 1 cycle after the request; writes commit at the sampling edge.
// Backpressure: none; requests arriving during the clear sweep are silently dropped.
// Ports: im_clk/im_rst; z_im_write_* write request; z_im_read_* request and registered response;
//        imem_init_busy_o high during the sweep; imem_access_err_o pulses on a rejected access.
module zilla_imem_bank
  import zilla_imem_pkg::*;
#(
  parameter int                    DATA_WIDTH     = IMEM_DATA_WIDTH,
  parameter int                    ADDR_WIDTH     = IMEM_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = IMEM_BASE_ADDR,
  parameter int                    DEPTH_WORDS    = IMEM_DEPTH_WORDS,
  parameter bit                    CLEAR_ON_RESET = 1'b1
) (
  input  logic                    im_clk,
  input  logic                    im_rst,
  input  logic                    z_im_write_en_i,
  input  logic [ADDR_WIDTH-1:0]   z_im_write_addr_i,
  input  logic [DATA_WIDTH-1:0]   z_im_write_data_i,
  input  logic [DATA_WIDTH/8-1:0] z_im_write_data_strobe_i,
  input  logic                    z_im_read_en_i,
  input  logic [ADDR_WIDTH-1:0]   z_im_read_addr_i,
  output logic [DATA_WIDTH-1:0]   z_im_read_data_o,
  output logic                    z_im_read_valid_o,
  output logic                    imem_init_busy_o,
  output logic                    imem_access_err_o
);

  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  imem_state_e state_q, state_d;
  logic [IW-1:0] clr_cnt_q, clr_cnt_d;
  logic valid_q, valid_d;
  logic err_q, err_d;
  logic zero_q, zero_d;  // response is forced to zero (reset or rejected read)
  logic rot_q, rot_d;    // upper 32-bit half was addressed

  logic                    wr_ok, rd_ok;
  logic [IW-1:0]           wr_idx, rd_idx;
  logic                    ram_we, ram_re;
  logic [IW-1:0]           ram_waddr;
  logic [DATA_WIDTH-1:0]   ram_wdata, ram_rdata;
  logic [DATA_WIDTH/8-1:0] ram_wstrb;

  // Address decode: writes need 8-byte alignment, reads 4-byte alignment.
  assign wr_ok = z_im_write_en_i && (z_im_write_addr_i[2:0] == 3'b000) &&
                 addr_in_range(32'(z_im_write_addr_i), 32'(BASE_ADDR), 32'(DEPTH_WORDS));
  assign rd_ok = z_im_read_en_i && (z_im_read_addr_i[1:0] == 2'b00) &&
                 addr_in_range(32'(z_im_read_addr_i), 32'(BASE_ADDR), 32'(DEPTH_WORDS));
  assign wr_idx = IW'(word_index(32'(z_im_write_addr_i), 32'(BASE_ADDR)));
  assign rd_idx = IW'(word_index(32'(z_im_read_addr_i), 32'(BASE_ADDR)));

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    zero_d    = zero_q;
    rot_d     = rot_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_waddr = wr_idx;
    ram_wdata = z_im_write_data_i;
    ram_wstrb = z_im_write_data_strobe_i;

    if (state_q == ST_CLEAR) begin
      // The sweep owns the write port; external traffic is dropped.
      ram_we    = 1'b1;
      ram_waddr = clr_cnt_q;
      ram_wdata = '0;
      ram_wstrb = '1;
      clr_cnt_d = clr_cnt_q + IW'(1);
      if (clr_cnt_q == IW'(DEPTH_WORDS - 1)) begin
        clr_cnt_d = '0;
        state_d   = ST_READY;
      end
    end else begin
      ram_we  = wr_ok;
      valid_d = z_im_read_en_i;
      // One shared pulse covers a bad read, a bad write, or both.
      err_d   = (z_im_write_en_i && !wr_ok) || (z_im_read_en_i && !rd_ok);
      if (z_im_read_en_i) begin
        ram_re = rd_ok;
        zero_d = !rd_ok;
        rot_d  = z_im_read_addr_i[2];
      end
    end
  end

  always_ff @(posedge im_clk) begin
    if (im_rst) begin
      state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      clr_cnt_q <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      zero_q    <= 1'b1;
      rot_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      zero_q    <= zero_d;
      rot_q     <= rot_d;
    end
  end

  zilla_imem_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH_WORDS),
    .AW         (IW)
  ) u_ram (
    .clk        (im_clk),
    .wr_en      (ram_we),
    .wr_addr    (ram_waddr),
    .wr_data    (ram_wdata),
    .wr_strb    (ram_wstrb),
    .rd_en      (ram_re),
    .rd_addr    (rd_idx),
    .rd_data_o  (ram_rdata)
  );

  // The RAM output register holds between reads, so the rotated, masked view
  // holds too. Rotating by 32 lands the addressed instruction in [31:0].
  assign z_im_read_data_o  = zero_q ? '0 :
                             (rot_q ? {ram_rdata[31:0], ram_rdata[DATA_WIDTH-1:32]} : ram_rdata);
  assign z_im_read_valid_o = valid_q;
  assign imem_access_err_o = err_q;
  assign imem_init_busy_o  = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_zilla_imem_bank.sv
module tb_zilla_imem_bank;

  localparam int          DW    = 64;
  localparam int          AW    = 20;
  localparam int          DEPTH = 16;
  localparam logic [19:0] BASE  = 20'h08000;

  logic          im_clk = 1'b0;
  logic          im_rst = 1'b1;
  logic          we = 1'b0;
  logic [AW-1:0] wa = '0;
  logic [DW-1:0] wd = '0;
  logic [7:0]    ws = '0;
  logic          re = 1'b0;
  logic [AW-1:0] ra = '0;
  logic [DW-1:0] rd_dat;
  logic          rd_vld, busy, err;

  always #5 im_clk = ~im_clk;

  zilla_imem_bank #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .BASE_ADDR      (BASE),
    .DEPTH_WORDS    (DEPTH),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .im_clk                   (im_clk),
    .im_rst                   (im_rst),
    .z_im_write_en_i          (we),
    .z_im_write_addr_i        (wa),
    .z_im_write_data_i        (wd),
    .z_im_write_data_strobe_i (ws),
    .z_im_read_en_i           (re),
    .z_im_read_addr_i         (ra),
    .z_im_read_data_o         (rd_dat),
    .z_im_read_valid_o        (rd_vld),
    .imem_init_busy_o         (busy),
    .imem_access_err_o        (err)
  );

  typedef struct packed {
    logic          vld;
    logic          err;
    logic [DW-1:0] dat;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] hold_dat;
  int            n_chk = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  function automatic logic in_rng(input logic [AW-1:0] a);
    int unsigned ai;
    ai = 32'(a);
    return (ai >= 32'(BASE)) && (ai < 32'(BASE) + 8 * DEPTH);
  endfunction

  function automatic int widx(input logic [AW-1:0] a);
    return int'((32'(a) - 32'(BASE)) >> 3);
  endfunction

  // Drive one READY-state cycle, predict the response from the bench's own
  // memory model, then compare it one cycle later.
  task automatic step(input string tag, input logic w_en, input logic [AW-1:0] w_a,
                      input logic [DW-1:0] w_d, input logic [7:0] w_s,
                      input logic r_en, input logic [AW-1:0] r_a);
    exp_t          e;
    logic          wr_ok, rd_ok;
    logic [DW-1:0] word;
    we = w_en; wa = w_a; wd = w_d; ws = w_s; re = r_en; ra = r_a;
    wr_ok = w_en && in_rng(w_a) && (w_a[2:0] == 3'b000);
    rd_ok = r_en && in_rng(r_a) && (r_a[1:0] == 2'b00);
    e.vld = r_en;
    e.err = (w_en && !wr_ok) || (r_en && !rd_ok);
    if (r_en) begin
      if (rd_ok) begin
        word     = model[widx(r_a)];
        hold_dat = r_a[2] ? {word[31:0], word[63:32]} : word;
      end else begin
        hold_dat = '0;
      end
    end
    e.dat = hold_dat;
    if (wr_ok) begin
      for (int b = 0; b < 8; b++) begin
        if (w_s[b]) model[widx(w_a)][8*b +: 8] = w_d[8*b +: 8];
      end
    end
    sb.push_back(e);
    @(posedge im_clk); #1;
    we = 1'b0; re = 1'b0;
    e = sb.pop_front();
    chk({tag, ".vld"}, 64'(rd_vld), 64'(e.vld));
    chk({tag, ".err"}, 64'(err), 64'(e.err));
    chk({tag, ".dat"}, rd_dat, e.dat);
  endtask

  // Count cycles until busy falls; nothing may come out while sweeping.
  task automatic wait_sweep(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge im_clk); #1;
      n++;
      chk({tag, ".vld"}, 64'(rd_vld), 64'd0);
      chk({tag, ".err"}, 64'(err), 64'd0);
      chk({tag, ".dat"}, rd_dat, hold_dat);
    end while (busy && n < 100);
    we = 1'b0; re = 1'b0;
    chk({tag, ".len"}, 64'(n), 64'd16);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  initial begin
    hold_dat = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    repeat (3) @(posedge im_clk);
    #1;
    chk("rst.dat", rd_dat, 64'd0);
    chk("rst.vld", 64'(rd_vld), 64'd0);
    chk("rst.err", 64'(err), 64'd0);
    chk("rst.busy", 64'(busy), 64'd1);
    im_rst = 1'b0;
    wait_sweep("sweep1");

    // First READY cycle is served.
    step("rd_first", 1'b0, '0, '0, 8'h00, 1'b1, 20'h08000);
    step("wr_strb", 1'b1, 20'h08008, 64'h1122334455667788, 8'h0F, 1'b0, '0);
    step("rd_lo", 1'b0, '0, '0, 8'h00, 1'b1, 20'h08008);
    step("rd_hi", 1'b0, '0, '0, 8'h00, 1'b1, 20'h0800C);
    step("wr_aa", 1'b1, 20'h08010, {16{4'hA}}, 8'hFF, 1'b0, '0);
    step("collide", 1'b1, 20'h08010, {16{4'h5}}, 8'hFF, 1'b1, 20'h08010);
    step("after_col", 1'b0, '0, '0, 8'h00, 1'b1, 20'h08010);
    step("oor_low", 1'b0, '0, '0, 8'h00, 1'b1, 20'h07FF8);
    step("oor_high", 1'b0, '0, '0, 8'h00, 1'b1, 20'h08080);
    step("last_word", 1'b0, '0, '0, 8'h00, 1'b1, 20'h08078);
    step("mis_wr", 1'b1, 20'h08004, {16{4'hF}}, 8'hFF, 1'b0, '0);
    step("mis_wr_chk", 1'b0, '0, '0, 8'h00, 1'b1, 20'h08000);
    step("mis_wr_chk4", 1'b0, '0, '0, 8'h00, 1'b1, 20'h08004);
    step("mis_rd", 1'b0, '0, '0, 8'h00, 1'b1, 20'h08002);
    step("both_bad", 1'b1, 20'h07FF0, 64'h1, 8'hFF, 1'b1, 20'h08001);
    step("rd_col_w", 1'b0, '0, '0, 8'h00, 1'b1, 20'h08014);
    step("idle_hold", 1'b0, '0, '0, 8'h00, 1'b0, '0);

    // Reset with a read pending, then reset again at sweep cycle 7; keep
    // requests active throughout to confirm they are dropped.
    we = 1'b1; wa = 20'h08004; wd = '1; ws = 8'hFF;
    re = 1'b1; ra = 20'h08008;
    im_rst = 1'b1;
    @(posedge im_clk); #1;
    hold_dat = '0;
    chk("rst2.vld", 64'(rd_vld), 64'd0);
    chk("rst2.dat", rd_dat, 64'd0);
    chk("rst2.err", 64'(err), 64'd0);
    chk("rst2.busy", 64'(busy), 64'd1);
    im_rst = 1'b0;
    repeat (7) @(posedge im_clk);
    #1;
    chk("mid.busy", 64'(busy), 64'd1);
    im_rst = 1'b1;
    @(posedge im_clk); #1;
    chk("rst3.busy", 64'(busy), 64'd1);
    im_rst = 1'b0;
    wait_sweep("sweep2");

    step("cleared", 1'b0, '0, '0, 8'h00, 1'b1, 20'h08010);
    for (int i = 1; i <= 4; i++) begin
      step("wr_stream", 1'b1, 20'(32'(BASE) + 8 * i),
           {32'hC0DE0000 + 32'(i), 32'h0000F000 + 32'(i)}, 8'hFF, 1'b0, '0);
    end
    for (int i = 1; i <= 4; i++) begin
      step("rd_stream", 1'b0, '0, '0, 8'h00, 1'b1, 20'(32'(BASE) + 8 * i + 4 * (i % 2)));
    end
    step("stream_end", 1'b0, '0, '0, 8'h00, 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
